// File: rtl/wb_rr_arbiter_pkg.sv
// Shared Wishbone widths, arbiter state encodings and types for wb_rr_arbiter.
// Widths and encodings live here as guarded defines so other Wishbone blocks can reuse them.
`ifndef WB_COM_AWIDTH
`define WB_COM_AWIDTH 32
`endif
`ifndef WB_COM_DWIDTH
`define WB_COM_DWIDTH 32
`endif
`ifndef WB_ARB_ST_IDLE
`define WB_ARB_ST_IDLE 2'b00
`endif
`ifndef WB_ARB_ST_OWN0
`define WB_ARB_ST_OWN0 2'b01
`endif
`ifndef WB_ARB_ST_OWN1
`define WB_ARB_ST_OWN1 2'b10
`endif

package wb_rr_arbiter_pkg;
    localparam int WB_AW = `WB_COM_AWIDTH;
    localparam int WB_DW = `WB_COM_DWIDTH;
    localparam int WB_SW = `WB_COM_DWIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE = `WB_ARB_ST_IDLE,
        ST_OWN0 = `WB_ARB_ST_OWN0,
        ST_OWN1 = `WB_ARB_ST_OWN1
    } arb_state_t;
endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Pipelined Wishbone (with stall) link; "master" drives requests, "slave" returns responses.
interface wb_rr_arbiter_if;
    import wb_rr_arbiter_pkg::*;

    logic [WB_AW-1:0] adr;
    logic [WB_DW-1:0] wdat;
    logic [WB_SW-1:0] sel;
    logic             cyc;
    logic             stb;
    logic             we;
    logic [WB_DW-1:0] rdat;
    logic             stall;
    logic             ack;
    logic             err;

    modport master (
        output adr, wdat, sel, cyc, stb, we,
        input  rdat, stall, ack, err
    );

    modport slave (
        input  adr, wdat, sel, cyc, stb, we,
        output rdat, stall, ack, err
    );
endinterface

// File: rtl/wb_rr_pick.sv
// Two-way round-robin choice: a lone request wins; on contention the master that is not last wins.
module wb_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end
endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master / one-slave pipelined Wishbone round-robin arbiter with per-grant outstanding limit.
// Optional slave watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter
    import wb_rr_arbiter_pkg::*;
#(
    parameter int MAX_OUTST = 4
`ifdef WB_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic            clk_i,
    input  logic            rst_i,
    wb_rr_arbiter_if.slave  m0,
    wb_rr_arbiter_if.slave  m1,
    wb_rr_arbiter_if.master s,
    output logic [1:0]      grant_o
);
    arb_state_t state, state_d;
    logic       last, last_d;
    logic [3:0] outst, outst_d;
    logic [1:0] pick;
    logic       own0, own1;
    logic       own_cyc, own_stb, own_we;
    logic       full, accept, resp, resp_cnt, abort;

    wb_rr_pick u_pick (
        .req   ({m1.cyc, m0.cyc}),
        .last  (last),
        .grant (pick)
    );

    assign own0    = (state == ST_OWN0);
    assign own1    = (state == ST_OWN1);
    assign own_cyc = (own0 & m0.cyc) | (own1 & m1.cyc);
    assign own_stb = (own0 & m0.stb) | (own1 & m1.stb);
    assign own_we  = (own0 & m0.we)  | (own1 & m1.we);
    assign full    = (outst == 4'(MAX_OUTST));

    // Slave side: control gated by ownership, data muxed straight from the owner.
    assign s.cyc  = own_cyc & ~abort;
    assign s.stb  = own_cyc & own_stb & ~full & ~abort;
    assign s.we   = own_we;
    assign s.adr  = own1 ? m1.adr  : m0.adr;
    assign s.wdat = own1 ? m1.wdat : m0.wdat;
    assign s.sel  = own1 ? m1.sel  : m0.sel;

    assign accept   = s.stb & ~s.stall;
    assign resp     = s.ack | s.err;
    assign resp_cnt = resp & (outst != 4'd0);

    assign m0.rdat  = s.rdat;
    assign m1.rdat  = s.rdat;
    assign m0.stall = own0 ? (s.stall | full) : 1'b1;
    assign m1.stall = own1 ? (s.stall | full) : 1'b1;
    assign m0.ack   = own0 & s.ack;
    assign m1.ack   = own1 & s.ack;
    assign m0.err   = own0 & (s.err | abort);
    assign m1.err   = own1 & (s.err | abort);

    assign grant_o = {own1, own0};

`ifdef WB_ARB_TIMEOUT_EN
    localparam int WD_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [WD_W-1:0] wd, wd_d;

    // Fires on the TIMEOUT_CYCLES-th consecutive response-free cycle with work outstanding.
    assign abort = own_cyc & (outst != 4'd0) & ~resp & (wd == WD_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wd_d = wd;
        if (!own_cyc || abort || resp || outst == 4'd0)
            wd_d = '0;
        else
            wd_d = wd + WD_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            wd <= '0;
        else
            wd <= wd_d;
    end
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d = state;
        last_d  = last;
        outst_d = outst;
        case (state)
            ST_IDLE: begin
                outst_d = 4'd0;
                if (pick[0]) begin
                    state_d = ST_OWN0;
                    last_d  = 1'b0;
                end else if (pick[1]) begin
                    state_d = ST_OWN1;
                    last_d  = 1'b1;
                end
            end
            ST_OWN0, ST_OWN1: begin
                // Dropping cyc aborts whatever is still outstanding.
                if (!own_cyc) begin
                    state_d = ST_IDLE;
                    outst_d = 4'd0;
                end else if (abort) begin
                    outst_d = 4'd0;
                end else if (accept && !resp_cnt) begin
                    outst_d = outst + 4'd1;
                end else if (!accept && resp_cnt) begin
                    outst_d = outst - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            last  <= 1'b1;
            outst <= 4'd0;
        end else begin
            state <= state_d;
            last  <= last_d;
            outst <= outst_d;
        end
    end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: reset, bursts, contention, outstanding limit, release, watchdog.
module tb_wb_rr_arbiter;
    import wb_rr_arbiter_pkg::*;

    logic       clk;
    logic       rst;
    logic [1:0] grant;
    int         tests;
    int         fails;

    wb_rr_arbiter_if m0_if ();
    wb_rr_arbiter_if m1_if ();
    wb_rr_arbiter_if s_if ();

    wb_rr_arbiter #(
        .MAX_OUTST(4)
`ifdef WB_ARB_TIMEOUT_EN
        , .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .m0      (m0_if),
        .m1      (m1_if),
        .s       (s_if),
        .grant_o (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all;
        m0_if.cyc = 0; m0_if.stb = 0; m0_if.we = 0;
        m0_if.adr = '0; m0_if.wdat = '0; m0_if.sel = '1;
        m1_if.cyc = 0; m1_if.stb = 0; m1_if.we = 0;
        m1_if.adr = '0; m1_if.wdat = '0; m1_if.sel = '1;
        s_if.stall = 0; s_if.ack = 0; s_if.err = 0; s_if.rdat = '0;
    endtask

    task automatic do_reset;
        idle_all();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset;
        idle_all();
        m0_if.cyc = 1; m0_if.stb = 1; m0_if.we = 1;
        s_if.ack = 1; s_if.err = 1;
        rst = 1;
        tick();
        tick();
        @(negedge clk);
        tests++;
        if (grant !== 2'b00) begin
            fails++; $display("FAIL reset_grant: got %b expected 00", grant);
        end
        tests++;
        if ({m1_if.stall, m0_if.stall} !== 2'b11) begin
            fails++; $display("FAIL reset_stall: got %b expected 11", {m1_if.stall, m0_if.stall});
        end
        tests++;
        if ({m0_if.ack, m1_if.ack, m0_if.err, m1_if.err} !== 4'b0000) begin
            fails++; $display("FAIL reset_ack_err: got %b expected 0000",
                              {m0_if.ack, m1_if.ack, m0_if.err, m1_if.err});
        end
        tests++;
        if ({s_if.cyc, s_if.stb, s_if.we} !== 3'b000) begin
            fails++; $display("FAIL reset_slave_ctl: got %b expected 000", {s_if.cyc, s_if.stb, s_if.we});
        end
        idle_all();
        rst = 0;
        tick();
    endtask

    task automatic test_single_burst;
        int  acks, sent, rdat_bad, m1_bad, grant_bad;
        logic pend;
        acks = 0; sent = 0; rdat_bad = 0; m1_bad = 0; grant_bad = 0; pend = 0;
        do_reset();
        m0_if.cyc = 1; m0_if.stb = 1;
        @(negedge clk);
        tests++;
        if ({grant, s_if.cyc, m0_if.stall} !== 4'b0001) begin
            fails++; $display("FAIL burst_pre_grant: got %b expected 0001", {grant, s_if.cyc, m0_if.stall});
        end
        tick();
        for (int c = 0; c < 12; c++) begin
            s_if.ack  = pend;
            s_if.rdat = 32'hA000 + 32'(acks);
            m0_if.stb = (sent < 8);
            m0_if.adr = 32'(sent * 4);
            @(negedge clk);
            if (m0_if.ack) begin
                if (m0_if.rdat !== 32'hA000 + 32'(acks)) rdat_bad++;
                acks++;
            end
            if (m1_if.stall !== 1'b1 || m1_if.ack !== 1'b0) m1_bad++;
            if (grant !== 2'b01) grant_bad++;
            pend = s_if.stb && !s_if.stall;
            if (pend) sent++;
            tick();
        end
        s_if.ack = 0;
        tests++;
        if (acks !== 8) begin
            fails++; $display("FAIL burst_acks: got %0d expected 8", acks);
        end
        tests++;
        if (rdat_bad !== 0) begin
            fails++; $display("FAIL burst_rdat: got %0d bad words expected 0", rdat_bad);
        end
        tests++;
        if (m1_bad !== 0) begin
            fails++; $display("FAIL burst_m1_blocked: got %0d bad cycles expected 0", m1_bad);
        end
        tests++;
        if (grant_bad !== 0) begin
            fails++; $display("FAIL burst_grant: got %0d bad cycles expected 0", grant_bad);
        end
        m0_if.cyc = 0; m0_if.stb = 0;
        @(negedge clk);
        tests++;
        if (s_if.cyc !== 1'b0) begin
            fails++; $display("FAIL burst_release_cyc: got %b expected 0", s_if.cyc);
        end
        tick();
    endtask

    task automatic test_contention;
        do_reset();
        m0_if.cyc = 1; m1_if.cyc = 1;
        @(negedge clk);
        tests++;
        if (grant !== 2'b00) begin
            fails++; $display("FAIL cont_latency: got %b expected 00", grant);
        end
        tick();
        @(negedge clk);
        tests++;
        if ({grant, m1_if.stall, m0_if.stall} !== 4'b0110) begin
            fails++; $display("FAIL cont_first_m0: got %b expected 0110", {grant, m1_if.stall, m0_if.stall});
        end
        tick();
        m0_if.cyc = 0;
        @(negedge clk);
        tests++;
        if ({grant, s_if.cyc} !== 3'b010) begin
            fails++; $display("FAIL cont_drop: got %b expected 010", {grant, s_if.cyc});
        end
        tick();
        @(negedge clk);
        tests++;
        if ({grant, m1_if.stall} !== 3'b001) begin
            fails++; $display("FAIL cont_idle_gap: got %b expected 001", {grant, m1_if.stall});
        end
        tick();
        @(negedge clk);
        tests++;
        if ({grant, m1_if.stall, s_if.cyc} !== 4'b1001) begin
            fails++; $display("FAIL cont_second_m1: got %b expected 1001", {grant, m1_if.stall, s_if.cyc});
        end
        m1_if.cyc = 0;
        tick();
    endtask

    task automatic test_max_outst;
        int acc;
        acc = 0;
        do_reset();
        m0_if.cyc = 1; m0_if.stb = 1;
        tick();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (s_if.stb && !s_if.stall) acc++;
            tick();
        end
        tests++;
        if (acc !== 4) begin
            fails++; $display("FAIL outst_fill: got %0d accepts expected 4", acc);
        end
        @(negedge clk);
        tests++;
        if ({m0_if.stall, s_if.stb} !== 2'b10) begin
            fails++; $display("FAIL outst_full: got stall,stb=%b expected 10", {m0_if.stall, s_if.stb});
        end
        tick();
        s_if.ack = 1;
        @(negedge clk);
        tests++;
        if ({m0_if.ack, s_if.stb} !== 2'b10) begin
            fails++; $display("FAIL outst_ack_full: got ack,stb=%b expected 10", {m0_if.ack, s_if.stb});
        end
        tick();
        s_if.ack = 0;
        acc = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (s_if.stb && !s_if.stall) acc++;
            tick();
        end
        tests++;
        if (acc !== 1) begin
            fails++; $display("FAIL outst_one_more: got %0d accepts expected 1", acc);
        end
        m0_if.cyc = 0; m0_if.stb = 0;
        tick();
    endtask

    task automatic test_simul_and_release;
        int acc;
        do_reset();
        m0_if.cyc = 1; m0_if.stb = 1;
        tick();
        tick();
        tick();
        s_if.ack = 1;
        @(negedge clk);
        tests++;
        if ({s_if.stb, m0_if.ack, m0_if.stall} !== 3'b110) begin
            fails++; $display("FAIL simul_accept_ack: got stb,ack,stall=%b expected 110",
                              {s_if.stb, m0_if.ack, m0_if.stall});
        end
        tick();
        s_if.ack = 0;
        acc = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (s_if.stb && !s_if.stall) acc++;
            tick();
        end
        tests++;
        if (acc !== 2) begin
            fails++; $display("FAIL simul_outst_kept: got %0d accepts expected 2", acc);
        end
        m0_if.stb = 0;
        s_if.ack = 1;
        tick();
        s_if.ack = 0;
        m0_if.cyc = 0;
        @(negedge clk);
        tests++;
        if ({grant, s_if.cyc} !== 3'b010) begin
            fails++; $display("FAIL abort_cyc_drop: got grant,cyc=%b expected 010", {grant, s_if.cyc});
        end
        tick();
        @(negedge clk);
        tests++;
        if (grant !== 2'b00) begin
            fails++; $display("FAIL abort_idle: got %b expected 00", grant);
        end
        m0_if.cyc = 1; m0_if.stb = 1;
        tick();
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (s_if.stb && !s_if.stall) acc++;
            tick();
        end
        tests++;
        if (acc !== 4) begin
            fails++; $display("FAIL abort_outst_cleared: got %0d accepts expected 4", acc);
        end
        m0_if.cyc = 0; m0_if.stb = 0;
        tick();
    endtask

    task automatic test_reset_mid_burst;
        do_reset();
        m1_if.cyc = 1; m1_if.stb = 1;
        tick();
        @(negedge clk);
        tests++;
        if (grant !== 2'b10) begin
            fails++; $display("FAIL midrst_own1: got %b expected 10", grant);
        end
        tick();
        m0_if.cyc = 1;
        rst = 1;
        tick();
        rst = 0;
        @(negedge clk);
        tests++;
        if ({grant, m1_if.stall, m0_if.stall, s_if.cyc, s_if.stb} !== 6'b001100) begin
            fails++; $display("FAIL midrst_idle: got grant,stalls,cyc,stb=%b expected 001100",
                              {grant, m1_if.stall, m0_if.stall, s_if.cyc, s_if.stb});
        end
        tick();
        @(negedge clk);
        tests++;
        if (grant !== 2'b01) begin
            fails++; $display("FAIL midrst_next_m0: got %b expected 01", grant);
        end
        m0_if.cyc = 0; m1_if.cyc = 0; m1_if.stb = 0;
        tick();
    endtask

    task automatic test_hung_slave;
        int err_bad, cyc_bad;
        err_bad = 0; cyc_bad = 0;
        do_reset();
        m0_if.cyc = 1; m0_if.stb = 1;
        tick();
        @(negedge clk);
        tests++;
        if (!(s_if.stb && !s_if.stall)) begin
            fails++; $display("FAIL hung_first_accept: got stb=%b expected 1", s_if.stb);
        end
        tick();
        m0_if.stb = 0;
`ifdef WB_ARB_TIMEOUT_EN
        for (int c = 1; c < 16; c++) begin
            @(negedge clk);
            if (m0_if.err !== 1'b0) err_bad++;
            if (s_if.cyc !== 1'b1) cyc_bad++;
            tick();
        end
        tests++;
        if (err_bad !== 0 || cyc_bad !== 0) begin
            fails++; $display("FAIL wd_quiet: got err_bad=%0d cyc_bad=%0d expected 0 0", err_bad, cyc_bad);
        end
        @(negedge clk);
        tests++;
        if ({m0_if.err, s_if.cyc, grant} !== 4'b1001) begin
            fails++; $display("FAIL wd_fire: got err,cyc,grant=%b expected 1001", {m0_if.err, s_if.cyc, grant});
        end
        tick();
        @(negedge clk);
        tests++;
        if ({m0_if.err, s_if.cyc, grant} !== 4'b0101) begin
            fails++; $display("FAIL wd_after: got err,cyc,grant=%b expected 0101", {m0_if.err, s_if.cyc, grant});
        end
`else
        for (int c = 1; c < 40; c++) begin
            @(negedge clk);
            if (m0_if.err !== 1'b0) err_bad++;
            if (s_if.cyc !== 1'b1) cyc_bad++;
            tick();
        end
        tests++;
        if (err_bad !== 0 || cyc_bad !== 0) begin
            fails++; $display("FAIL hung_no_wd: got err_bad=%0d cyc_bad=%0d expected 0 0", err_bad, cyc_bad);
        end
`endif
        m0_if.cyc = 0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        tests = 0;
        fails = 0;
        rst = 1;
        idle_all();
        test_reset();
        test_single_burst();
        test_contention();
        test_max_outst();
        test_simul_and_release();
        test_reset_mid_burst();
        test_hung_slave();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Two-master, one-slave Wishbone (pipelined, with stall) round-robin arbiter. It sits in front of a single shared slave, such as the on-chip RAM, so that the CPU cluster and a second bus master (DMA or debug) can share it without a full crossbar. It bounds the number of outstanding transfers per grant and keeps ownership for a whole `cyc` burst.

## Interface
Parameters:
- MAX_OUTST, 4: maximum accepted-but-unacknowledged strobes per grant; range 1..15.
- TIMEOUT_CYCLES, 255: watchdog limit in cycles; present only with the macro (see Configuration).

Ports (N = 0, 1 denotes one line per master):
- clk_i, in, 1: sole clock.
- rst_i, in, 1: synchronous, active-high reset.
- mN_wb_adr_i, in, `WB_COM_AWIDTH: master address.
- mN_wb_dat_i, in, `WB_COM_DWIDTH: master write data.
- mN_wb_sel_i, in, `WB_COM_DWIDTH/8: byte selects.
- mN_wb_cyc_i / mN_wb_stb_i / mN_wb_we_i, in, 1 each: cycle, strobe, write enable.
- mN_wb_dat_o, out, `WB_COM_DWIDTH: read data, shared from the slave.
- mN_wb_stall_o / mN_wb_ack_o / mN_wb_err_o, out, 1 each.
- s_wb_adr_o / s_wb_dat_o / s_wb_sel_o, out: muxed from the owner; widths as above.
- s_wb_cyc_o / s_wb_stb_o / s_wb_we_o, out, 1 each.
- s_wb_dat_i, in, `WB_COM_DWIDTH; s_wb_stall_i / s_wb_ack_i / s_wb_err_i, in, 1 each.
- grant_o, out, 2: one-hot current owner, with 00 meaning idle (debug and visibility).

## Operation
- States are IDLE, OWN0 and OWN1, held in a registered `state` plus a `last` bit that records the most recently granted master.
- In IDLE:
  - If only one `mN_wb_cyc_i` is high, grant that master.
  - If both are high, grant the master that is not `last`.
  - The grant is registered, so the state changes on the next edge.
- In OWNn:
  - Slave outputs pass straight through from master n.
  - `mn_wb_ack_o` = `s_wb_ack_i`, `mn_wb_err_o` = `s_wb_err_i`, `mn_wb_dat_o` = `s_wb_dat_i`.
  - `mn_wb_stall_o` = `s_wb_stall_i` | (`outst` == MAX_OUTST).
  - `s_wb_stb_o` = `mn_wb_stb_i` & `outst` != MAX_OUTST.
- A non-owner always sees stall=1, ack=0, err=0, and dat_o equal to the slave data (not qualified).
- In IDLE, all `s_wb_*` control outputs are 0 and both masters see stall=1.
- Outstanding counter `outst` (4 bits):
  - Increments on an accepted strobe (`s_wb_stb_o` & !`s_wb_stall_i`).
  - Decrements on `s_wb_ack_i` | `s_wb_err_i`.
  - Accept and response in the same cycle leave it unchanged.
  - It never wraps: a response while it is 0 is ignored.
- Release: when the owner's `cyc_i` is low, `s_wb_cyc_o` drops combinationally in the same cycle. On the next edge the state goes to IDLE and `outst` is cleared (this is an abort per Wishbone). `last` is updated at grant time.
- Reset mid-burst: the next edge returns to IDLE with `outst`=0 and `last`=1, and all outputs take their reset values.

## Timing
- Reset values:
  - state=IDLE, `last`=1 (so m0 wins first contention), `outst`=0, `grant_o`=00.
  - All ack/err outputs and all `s_wb_cyc/stb/we_o` are 0; both stall outputs are 1.
- Grant latency:
  - `cyc` rising in cycle t leads to the grant at edge t+1.
  - The first strobe can reach the slave in cycle t+1.
- Handover takes at least one IDLE cycle. The owner's `cyc` falling in cycle t gives IDLE in t+1, and the other master is granted in t+2.
- Data, ack and err paths are purely combinational with zero added latency. Only the grant and counter are registered.

## Configuration
- With `WB_ARB_TIMEOUT_EN` defined:
  - An 8-bit-or-wider watchdog counts cycles with `outst` > 0 and no ack/err, and resets on any response.
  - On reaching TIMEOUT_CYCLES it asserts `mn_wb_err_o` for exactly one cycle, forces `s_wb_cyc_o`=0 in that cycle, and clears `outst` and the watchdog.
  - The grant is kept.
- Without the macro there is no watchdog, and a hung slave blocks the bus indefinitely.

## Structure
- State encodings (IDLE=2'b00, OWN0=2'b01, OWN1=2'b10) go in the shared Wishbone defines header next to `WB_COM_AWIDTH/DWIDTH`.
- The round-robin choice goes in one sub-module, `wb_rr_pick`, which is combinational with inputs req[1:0] and last and output a one-hot grant. The state, counter and mux stay in the top.

## Test plan
- Single master, 8 back-to-back reads with the slave acking every cycle: all 8 acks reach m0, m1 sees stall=1 throughout, and `grant_o`=01.
- Both `cyc` rise in the same cycle after reset: m0 is granted first; when m0 drops `cyc`, one IDLE cycle follows, then `grant_o`=10.
- MAX_OUTST=4 with the slave withholding ack: after 4 accepted strobes m0 stall=1 and `s_wb_stb_o`=0; one ack gives exactly one more accept.
- Simultaneous accept and ack at `outst`=2: `outst` stays 2. The owner dropping `cyc` with `outst`=3 gives `s_wb_cyc_o`=0 in the same cycle and `outst`=0 next.
- `rst_i` pulsed during an OWN1 burst: the next cycle shows IDLE, `grant_o`=00, and both stalls=1; the following contention grants m0.
- With `WB_ARB_TIMEOUT_EN` and TIMEOUT_CYCLES=16, the slave never acks: the owner sees err=1 for one cycle at cycle 16 after the last strobe and `s_wb_cyc_o` pulses low; without the macro err stays 0.
